dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 32-word data memory (`DATAMEM`) between two requesters: port 0 is the CPU load/store stage and port 1 is the I/O/DMA master. It selects at most one requester per cycle using round-robin, drives the memory's `Addr`/`Din`/`We`, and returns a registered acknowledge and read data one cycle later. It also flags out-of-range and misaligned addresses without touching memory. It sits between both masters and `DATAMEM`; the memory read path is combinational and the write path commits on the `Clk` rising edge.

## Interface

Parameters:
- `AW`, 32: address width (byte address)
- `DW`, 32: data width
- `WORDS`, 32: memory depth in words; valid word index is `Addr[6:2]`

Ports:
- `Clk` in 1: single clock, rising edge
- `Rst` in 1: reset, asynchronous, active-high
- `Req0`/`Req1` in 1: access request, held until `Ack`
- `We0`/`We1` in 1: 1 = write, 0 = read
- `Addr0`/`Addr1` in AW: byte address
- `Din0`/`Din1` in DW: write data
- `Ack0`/`Ack1` out 1: one-cycle completion pulse, registered
- `Err0`/`Err1` out 1: valid only with `Ack`; access rejected
- `Dout0`/`Dout1` out DW: read data, registered; holds its value between reads
- `MemAddr` out AW: to `DATAMEM.Addr`
- `MemDin` out DW: to `DATAMEM.Din`
- `MemWe` out 1: to `DATAMEM.We`
- `MemDout` in DW: from `DATAMEM.Dout`

## Operation

- **Eligibility:** requester n is eligible when `ReqN=1` and `AckN=0` in the current cycle. The cycle in which `AckN` is high masks that requester, so a requester gets at most one access every 2 cycles.
- **Grant (combinational):**
  - Only one requester eligible: it wins.
  - Both eligible: the requester not recorded in `last` wins.
  - `last` resets to 1, so port 0 wins the first tie.
- **Address check:**
  - `bad = (Addr[1:0] != 0) || (Addr[AW-1:7] != 0)`.
  - A bad access still wins arbitration and is acknowledged with `Err=1`.
  - `MemWe` stays 0 and `Dout` is unchanged.
- **Memory drive:**
  - With a grant: `MemAddr`/`MemDin` carry the winner's `Addr`/`Din`, and `MemWe = We & ~bad`.
  - With no grant: `MemAddr=0`, `MemDin=0`, `MemWe=0`.
  - While `Rst` is high: `MemWe=0`.
- **Completion, at the edge ending the grant cycle:**
  - `AckN<=1` and `ErrN<=bad`; `last<=N`.
  - On a good read: `DoutN<=MemDout`.
  - On a write, `Dout` is unchanged.
  - The non-granted `Ack`/`Err` signals go to 0 at the same edge.
- **Back-to-back:** if `ReqN` is still 1 in the cycle after `AckN`, that is a new request. The master must update `Addr`/`We`/`Din` in its `Ack` cycle, or drop `Req`.
- **Same-word hazard:** port 0 writes word k in cycle t and port 1 reads k in cycle t+1. The read returns the new data, because the write has already committed.

## Timing

- Latency is 1 cycle from grant to `Ack`; write commit happens on the same edge as `Ack`.
- Throughput:
  - 1 access per cycle with both requesters active (alternating 0,1,0,1).
  - 1 access per 2 cycles for a single requester.
- Reset values: `Ack0=Ack1=0`, `Err0=Err1=0`, `Dout0=Dout1=0`, `last=1`. Memory outputs follow the no-grant drive.
- Reset mid-operation: a pending `Ack` is cleared immediately and no write is issued while `Rst=1`. A write already committed before `Rst` rose stays in memory.
- No internal timeout. A requester that never drops `Req` is limited to 50% of the bandwidth when the other side is active.

## Structure

- Shared package `dmem_pkg`:
  - `DMEM_WORDS=32`
  - `DMEM_IDX_LSB=2`, `DMEM_IDX_MSB=6`
  - port-id constants `PORT_CPU=0`, `PORT_IO=1`
  - the `bad`-address function
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are `elig[1:0]` and `last`; outputs are `gnt_valid` and `gnt_id`.
- Top level holds the `last`, `Ack`, `Err` and `Dout` registers and the memory drive mux. `DATAMEM` is instantiated outside, in the CPU top.

## Test plan

- Reset: assert `Rst` with `Req0=1`, `We0=1`. Expect `MemWe=0`, `Ack0=0`, `Dout0=0`, and no write to `DATAMEM`.
- Single write then read: port 0 writes `0xDEADBEEF` to `0x14`, then reads `0x14`.
  - `Ack0` pulses in cycles 1 and 3.
  - `Dout0=0xDEADBEEF` after the second `Ack`.
  - `Ack0` is never high in two consecutive cycles.
- Contention: `Req0` and `Req1` are held high with reads of `0x00` and `0x04`. Grants alternate 0,1,0,1 starting with port 0, and `Ack0`/`Ack1` alternate every cycle.
- Error: port 1 writes `0x42` to `0x81`, then to `0x80`.
  - Both accesses get `Ack1=1`, `Err1=1`.
  - `MemWe` stays 0.
  - A later read of `0x00` returns its previous value.
- Hazard: port 0 writes `0x1234` to `0x1C` while port 1 reads `0x1C` in the next cycle. Expect `Dout1=0x1234`.
- Reset mid-access: assert `Rst` in the cycle `Ack1=1`. `Ack1` drops immediately, and after release port 0 wins the first tie.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and address-check helper for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_WORDS   = 32;
  localparam int DMEM_IDX_LSB = 2;
  localparam int DMEM_IDX_MSB = 6;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  // Misaligned or beyond the 128-byte window of the 32-word memory.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:7] != 25'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; on a tie the port not in last wins.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Select the winner among eligible requesters.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = PORT_CPU;
    case (elig)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = PORT_CPU;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = PORT_IO;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = PORT_CPU;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and I/O (port 1)
// masters with round-robin arbitration and registered ack/err/read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int WORDS = DMEM_WORDS
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req0,
  input  logic          We0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] Din0,
  output logic          Ack0,
  output logic          Err0,
  output logic [DW-1:0] Dout0,
  input  logic          Req1,
  input  logic          We1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Din1,
  output logic          Ack1,
  output logic          Err1,
  output logic [DW-1:0] Dout1,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemDin,
  output logic          MemWe,
  input  logic [DW-1:0] MemDout
);

  logic          last_r;
  logic          ack0_r, ack1_r, err0_r, err1_r;
  logic [DW-1:0] dout0_r, dout1_r;

  logic [1:0]    elig_s;
  logic          gnt_valid_s, gnt_id_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_din_s;
  logic          win_we_s;
  logic          bad_s;

  // The Ack cycle masks a port; reset forces the no-grant drive.
  assign elig_s = {Req1 & ~ack1_r & ~Rst, Req0 & ~ack0_r & ~Rst};

  rr_pick2 u_pick (
    .elig      (elig_s),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Route the winning requester's access fields.
  always_comb begin
    win_addr_s = Addr0;
    win_din_s  = Din0;
    win_we_s   = We0;
    if (gnt_id_s == PORT_IO) begin
      win_addr_s = Addr1;
      win_din_s  = Din1;
      win_we_s   = We1;
    end else begin
      win_addr_s = Addr0;
      win_din_s  = Din0;
      win_we_s   = We0;
    end
  end

  assign bad_s = addr_bad(32'(win_addr_s)) ||
                 (int'(win_addr_s[DMEM_IDX_MSB:DMEM_IDX_LSB]) >= WORDS);

  // Drive the memory port; idle drive is all zeros.
  always_comb begin
    MemAddr = '0;
    MemDin  = '0;
    MemWe   = 1'b0;
    if (gnt_valid_s) begin
      MemAddr = win_addr_s;
      MemDin  = win_din_s;
      MemWe   = win_we_s & ~bad_s & ~Rst;
    end else begin
      MemAddr = '0;
      MemDin  = '0;
      MemWe   = 1'b0;
    end
  end

  // Completion registers and round-robin history.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      last_r  <= PORT_IO;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
      dout0_r <= '0;
      dout1_r <= '0;
    end else begin
      ack0_r <= gnt_valid_s & (gnt_id_s == PORT_CPU);
      ack1_r <= gnt_valid_s & (gnt_id_s == PORT_IO);
      err0_r <= gnt_valid_s & (gnt_id_s == PORT_CPU) & bad_s;
      err1_r <= gnt_valid_s & (gnt_id_s == PORT_IO) & bad_s;
      if (gnt_valid_s) begin
        last_r <= gnt_id_s;
      end else begin
        last_r <= last_r;
      end
      if (gnt_valid_s && !bad_s && !win_we_s && (gnt_id_s == PORT_CPU)) begin
        dout0_r <= MemDout;
      end else begin
        dout0_r <= dout0_r;
      end
      if (gnt_valid_s && !bad_s && !win_we_s && (gnt_id_s == PORT_IO)) begin
        dout1_r <= MemDout;
      end else begin
        dout1_r <= dout1_r;
      end
    end
  end

  assign Ack0  = ack0_r;
  assign Ack1  = ack1_r;
  assign Err0  = err0_r;
  assign Err1  = err1_r;
  assign Dout0 = dout0_r;
  assign Dout1 = dout1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'd0, din0 = 32'd0, addr1 = 32'd0, din1 = 32'd0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] dout0, dout1;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we;
  logic        init_en = 1'b1;
  logic [31:0] mem [0:31];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .Clk(clk), .Rst(rst),
    .Req0(req0), .We0(we0), .Addr0(addr0), .Din0(din0),
    .Ack0(ack0), .Err0(err0), .Dout0(dout0),
    .Req1(req1), .We1(we1), .Addr1(addr1), .Din1(din1),
    .Ack1(ack1), .Err1(err1), .Dout1(dout1),
    .MemAddr(mem_addr), .MemDin(mem_din), .MemWe(mem_we), .MemDout(mem_dout)
  );

  // Memory model: word i preloads to 0x10000000+i, then commits writes.
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr[6:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h14; din0 = 32'hAAAA_5555;
    tick(); tick();
    init_en = 1'b0;
    tick(); tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_memwe got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_memaddr got=%h exp=0", mem_addr); end
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b exp=0", ack0); end
    total++; if (dout0 !== 32'd0) begin bad++; $display("FAIL rst_dout0 got=%h exp=0", dout0); end
    total++; if (mem[5] !== 32'h1000_0005) begin bad++; $display("FAIL rst_nowrite got=%h exp=10000005", mem[5]); end
    req0 = 1'b0; we0 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic exp0 [4];
    logic [31:0] exp_addr [4];
    exp0[0] = 1'b1; exp0[1] = 1'b0; exp0[2] = 1'b1; exp0[3] = 1'b0;
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h0; exp_addr[3] = 32'h4;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h04;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (mem_addr !== exp_addr[c]) begin bad++; $display("FAIL cont_addr[%0d] got=%h exp=%h", c, mem_addr, exp_addr[c]); end
      tick();
      total++; if (ack0 !== exp0[c] || ack1 !== ~exp0[c]) begin bad++; $display("FAIL cont_ack[%0d] got=%b%b exp=%b%b", c, ack1, ack0, ~exp0[c], exp0[c]); end
    end
    total++; if (dout0 !== 32'h1000_0000) begin bad++; $display("FAIL cont_dout0 got=%h exp=10000000", dout0); end
    total++; if (dout1 !== 32'h1000_0001) begin bad++; $display("FAIL cont_dout1 got=%h exp=10000001", dout1); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h14; din0 = 32'hDEAD_BEEF;
    #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h14) begin bad++; $display("FAIL wr_drive got=%b/%h exp=1/14", mem_we, mem_addr); end
    tick();
    total++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b/%b exp=1/0", ack0, err0); end
    total++; if (mem[5] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_commit got=%h exp=deadbeef", mem[5]); end
    we0 = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin bad++; $display("FAIL wr_masked got=%b/%h exp=0/0", mem_we, mem_addr); end
    tick();
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rd_gap got=%b exp=0", ack0); end
    tick();
    total++; if (ack0 !== 1'b1 || dout0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%b/%h exp=1/deadbeef", ack0, dout0); end
    req0 = 1'b0;
    tick();
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rd_end got=%b exp=0", ack0); end
  endtask

  task automatic test_error();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h81; din1 = 32'h42;
    #1;
    total++; if (mem_we !== 1'b0 || mem_addr !== 32'h81) begin bad++; $display("FAIL err1_drive got=%b/%h exp=0/81", mem_we, mem_addr); end
    tick();
    total++; if (ack1 !== 1'b1 || err1 !== 1'b1) begin bad++; $display("FAIL err1_ack got=%b/%b exp=1/1", ack1, err1); end
    total++; if (dout1 !== 32'h1000_0001) begin bad++; $display("FAIL err1_dout got=%h exp=10000001", dout1); end
    addr1 = 32'h80;
    tick();
    #1;
    total++; if (mem_we !== 1'b0 || mem_addr !== 32'h80) begin bad++; $display("FAIL err2_drive got=%b/%h exp=0/80", mem_we, mem_addr); end
    tick();
    total++; if (ack1 !== 1'b1 || err1 !== 1'b1) begin bad++; $display("FAIL err2_ack got=%b/%b exp=1/1", ack1, err1); end
    we1 = 1'b0; addr1 = 32'h00;
    tick(); tick();
    total++; if (ack1 !== 1'b1 || err1 !== 1'b0 || dout1 !== 32'h1000_0000) begin bad++; $display("FAIL err_read got=%b/%b/%h exp=1/0/10000000", ack1, err1, dout1); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_hazard();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1C; din0 = 32'h1234;
    tick();
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL haz_wack got=%b exp=1", ack0); end
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1C;
    tick();
    total++; if (ack1 !== 1'b1 || dout1 !== 32'h1234) begin bad++; $display("FAIL haz_read got=%b/%h exp=1/00001234", ack1, dout1); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h04;
    tick();
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL mid_ack got=%b exp=1", ack1); end
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; din0 = 32'hCAFE_0000;
    #1;
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL mid_drop got=%b exp=0", ack1); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_memwe got=%b exp=0", mem_we); end
    tick();
    total++; if (mem[2] !== 32'h1000_0002) begin bad++; $display("FAIL mid_nowrite got=%h exp=10000002", mem[2]); end
    we0 = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (mem_addr !== 32'h08) begin bad++; $display("FAIL mid_tie got=%h exp=00000008", mem_addr); end
    tick();
    total++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || dout0 !== 32'h1000_0002) begin bad++; $display("FAIL mid_after got=%b/%b/%h exp=1/0/10000002", ack0, ack1, dout0); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_error();
    test_hazard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
